sseg_scanner: RTL

//  Time-multiplexes the four active-low 7-segment patterns from the status indicator stage (hex_0..hex_3)

---
 rtl/sseg_pkg.sv | 21 ++
 rtl/sseg_slot_timer.sv | 72 +++++++
 rtl/sseg_scanner.sv | 117 +++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the scanned 7-segment display driver.
// Build option: SSEG_SCANNER_DIM_EN (see sseg_scanner.sv).
package sseg_pkg;

    localparam int         NDIG    = 4;
    localparam logic [6:0] SEG_OFF = 7'h7f;
    localparam logic [3:0] DIG_OFF = 4'hf;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Active-low one-hot enable for the digit currently being shown.
    function automatic logic [3:0] dig_enable_n(input logic [1:0] idx);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << idx;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot timer: counts clocks within a digit slot, steps the digit index on
// each wrap, runs the BLANK/SHOW phase machine and flags the frame start.
module sseg_slot_timer
    import sseg_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [15:0] BLANK_CYC = 16'd500
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [1:0]  idx,
    output scan_state_e state,
    output logic        frame_start
);

    logic [15:0] cnt_r;
    logic [1:0]  idx_r;
    scan_state_e state_r;
    scan_state_e state_s;
    logic        wrap_s;

    assign wrap_s      = (cnt_r == (SCAN_DIV - 16'd1));
    assign idx         = idx_r;
    assign state       = state_r;
    // A frame begins at the first clock of digit 0's slot.
    assign frame_start = (cnt_r == 16'd0) && (idx_r == 2'd0);

    // Slot clock counter and digit index, advancing together on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
            idx_r <= 2'd0;
        end else if (wrap_s) begin
            cnt_r <= 16'd0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    // Phase state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BLANK;
        end else begin
            state_r <= state_s;
        end
    end

    // Phase transitions: blank for BLANK_CYC clocks, then show until the slot ends.
    always_comb begin
        state_s = state_r;
        case (state_r)
            BLANK: begin
                if (cnt_r == (BLANK_CYC - 16'd1)) begin
                    state_s = SHOW;
                end else begin
                    state_s = BLANK;
                end
            end
            SHOW: begin
                if (wrap_s) begin
                    state_s = BLANK;
                end else begin
                    state_s = SHOW;
                end
            end
            default: state_s = BLANK;
        endcase
    end

endmodule

// File: rtl/sseg_scanner.sv
// Scanned 4-digit 7-segment driver. Digits are snapshotted once per frame
// and shown one at a time with a blank gap between digits.
// Build option: SSEG_SCANNER_DIM_EN adds a bright[3:0] input and a
// 16-step PWM gate on the segment bus during the show phase.
module sseg_scanner
    import sseg_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [15:0] BLANK_CYC = 16'd500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] hex_0,
    input  logic [6:0] hex_1,
    input  logic [6:0] hex_2,
    input  logic [6:0] hex_3,
`ifdef SSEG_SCANNER_DIM_EN
    input  logic [3:0] bright,
`endif
    output logic [6:0] seg_n,
    output logic [3:0] dig_n,
    output logic       frame_tick
);

    logic [1:0]  idx_s;
    scan_state_e state_s;
    logic        frame_start_s;
    logic [6:0]  shadow_r [NDIG];
    logic [6:0]  seg_s;
    logic [3:0]  dig_s;
    logic        drive_s;
    logic [6:0]  seg_n_r;
    logic [3:0]  dig_n_r;
    logic        frame_tick_r;

    sseg_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx         (idx_s),
        .state       (state_s),
        .frame_start (frame_start_s)
    );

    // Frame snapshot of all digits so a frame never mixes old and new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                shadow_r[i] <= SEG_OFF;
            end
        end else if (frame_start_s) begin
            shadow_r[0] <= hex_0;
            shadow_r[1] <= hex_1;
            shadow_r[2] <= hex_2;
            shadow_r[3] <= hex_3;
        end
    end

`ifdef SSEG_SCANNER_DIM_EN
    logic [3:0] pwm_r;
    logic [3:0] bright_r;

    // Free-running PWM phase and per-frame brightness sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r    <= 4'd0;
            bright_r <= 4'hf;
        end else begin
            pwm_r <= pwm_r + 4'd1;
            if (frame_start_s) begin
                bright_r <= bright;
            end
        end
    end

    assign drive_s = (bright_r == 4'hf) || (pwm_r < bright_r);
`else
    assign drive_s = 1'b1;
`endif

    // Output selection: blank bus in BLANK, current digit's shadow in SHOW.
    always_comb begin
        seg_s = SEG_OFF;
        dig_s = DIG_OFF;
        if (state_s == SHOW) begin
            dig_s = dig_enable_n(idx_s);
            if (drive_s) begin
                seg_s = shadow_r[idx_s];
            end else begin
                seg_s = SEG_OFF;
            end
        end else begin
            seg_s = SEG_OFF;
            dig_s = DIG_OFF;
        end
    end

    // Registered pins; reset blanks the display without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n_r      <= SEG_OFF;
            dig_n_r      <= DIG_OFF;
            frame_tick_r <= 1'b0;
        end else begin
            seg_n_r      <= seg_s;
            dig_n_r      <= dig_s;
            frame_tick_r <= frame_start_s;
        end
    end

    assign seg_n      = seg_n_r;
    assign dig_n      = dig_n_r;
    assign frame_tick = frame_tick_r;

endmodule
